// File: rtl/pe_mac_pipe.sv
// Pipelined systolic-array processing element.
// Forwards a/b/valid east/south with one register stage. Mode 0 computes a
// per-beat MAC (out = c + a*b). Mode 1 accumulates K products locally, seeded
// by c_in on the first beat, and emits one result per set.
// Optional macro PE_SAT_EN: saturating adds with an ovf strobe. When it is not
// defined, the adds wrap and ovf is tied low.
module pe_mac_pipe #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned K  = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [AW-1:0] c_in,
  input  logic          in_valid,
  input  logic          mode,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          fwd_valid,
  output logic [AW-1:0] out,
  output logic          out_valid,
  output logic          busy,
  output logic          ovf
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  // Forwarding registers
  logic [DW-1:0] r_a_out;
  logic [DW-1:0] r_b_out;
  logic          r_fwd_valid;

  // Stage-1 registers
  logic [AW-1:0] r_p;
  logic [AW-1:0] r_c;
  logic          r_s1_valid;
  logic          r_s1_mode;
  logic          r_s1_first;
  logic          r_s1_last;

  // Set tracking and stage-2 state
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic [AW-1:0] r_acc;
  logic          r_acc_open;
  logic [AW-1:0] r_out;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_ovf;
`ifdef PE_SAT_EN
  logic          r_sat;
`endif

  // Combinational signals
  logic [PW-1:0] w_prod;
  logic [AW-1:0] w_p;
  logic          w_first;
  logic          w_last;
  logic          w_eff_mode;
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_res;
  logic          w_sat;
`ifdef PE_SAT_EN
  logic [AW:0]   w_sum_ext;
`endif
  logic [CW-1:0] w_cnt_nxt;
  logic          w_mode_nxt;
  logic [AW-1:0] w_acc_nxt;
  logic          w_open_nxt;
  logic [AW-1:0] w_out_nxt;
  logic          w_out_valid_nxt;
  logic          w_ovf_nxt;
  logic          w_busy_nxt;

  // Full-width product, then zero-extended or truncated to the accumulator width
  assign w_prod = PW'(a_in) * PW'(b_in);
  assign w_p    = AW'(w_prod);

  // Beat position and effective mode; the mode pin only matters at a set boundary
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_eff_mode = w_first ? mode : r_mode;

  // Stage-2 adder: seed comes from c on a first beat, from the accumulator otherwise
  always_comb begin
    w_base = (r_s1_mode && !r_s1_first) ? r_acc : r_c;
`ifdef PE_SAT_EN
    w_sum_ext = {1'b0, w_base} + {1'b0, r_p};
    w_sat     = w_sum_ext[AW] | (r_s1_mode & ~r_s1_first & r_sat);
    w_res     = w_sat ? '1 : w_sum_ext[AW-1:0];
`else
    w_res = w_base + r_p;
    w_sat = 1'b0;
`endif
  end

  // Next-state: beat counter, latched mode, accumulator and result
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_mode_nxt      = r_mode;
    w_acc_nxt       = r_acc;
    w_open_nxt      = r_acc_open;
    w_out_nxt       = r_out;
    w_out_valid_nxt = 1'b0;
    w_ovf_nxt       = 1'b0;

    if (in_valid) begin
      if (w_first) begin
        w_mode_nxt = mode;
      end
      if (w_eff_mode) begin
        w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
      end
    end

    if (r_s1_valid) begin
      if (!r_s1_mode || r_s1_last) begin
        w_out_nxt       = w_res;
        w_out_valid_nxt = 1'b1;
        w_ovf_nxt       = w_sat;
        if (r_s1_mode) begin
          w_acc_nxt  = '0;
          w_open_nxt = 1'b0;
        end
      end else begin
        w_acc_nxt  = w_res;
        w_open_nxt = 1'b1;
      end
    end

    w_busy_nxt = (w_cnt_nxt != '0) | in_valid | w_open_nxt;
  end

  // Neighbour forwarding, unconditional every cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_out     <= '0;
      r_b_out     <= '0;
      r_fwd_valid <= 1'b0;
    end else begin
      r_a_out     <= a_in;
      r_b_out     <= b_in;
      r_fwd_valid <= in_valid;
    end
  end

  // Stage-1 capture of product, seed and beat tags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_p        <= '0;
      r_c        <= '0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_p        <= w_p;
      r_c        <= c_in;
      r_s1_valid <= in_valid;
      r_s1_mode  <= w_eff_mode;
      r_s1_first <= w_first;
      r_s1_last  <= w_last;
    end
  end

  // Set tracking, accumulator and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_acc_open  <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_mode      <= w_mode_nxt;
      r_acc       <= w_acc_nxt;
      r_acc_open  <= w_open_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

`ifdef PE_SAT_EN
  // Sticky saturation flag carried across the remainder of a mode-1 set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sat <= 1'b0;
    end else if (r_s1_valid && r_s1_mode) begin
      r_sat <= r_s1_last ? 1'b0 : w_sat;
    end
  end
`endif

  assign a_out     = r_a_out;
  assign b_out     = r_b_out;
  assign fwd_valid = r_fwd_valid;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign ovf       = r_ovf;

endmodule

// File: doc/pe_mac_pipe.md
Name: pe_mac_pipe

Overview:
Parametrised, pipelined processing element for the systolic array; successor to the single-cycle c + a*b PE.
- Forwards a/b to neighbours with one register stage and valid tagging.
- Mode 0: per-beat MAC (out = c + a*b).
- Mode 1: output-stationary, accumulating K products locally before emitting one result.

Parameters:
DW, 32, operand width of a/b (unsigned)
AW, 64, accumulator/partial-sum width of c/out (AW >= 2*DW not required)
K, 4, products per accumulation in mode 1 (K >= 1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
a_in  in  DW  operand from west neighbour
b_in  in  DW  operand from north neighbour
c_in  in  AW  partial sum in (mode 0) / seed on first beat (mode 1)
in_valid  in  1  beat qualifier for a_in/b_in/c_in
mode  in  1  0 = pass-through MAC, 1 = local accumulate
a_out  out  DW  registered a_in to east neighbour
b_out  out  DW  registered b_in to south neighbour
fwd_valid  out  1  registered in_valid
out  out  AW  result
out_valid  out  1  one-cycle strobe, out is valid
busy  out  1  accumulation open or pipeline occupied
ovf  out  1  overflow strobe with out_valid (0 unless PE_SAT_EN)

Behaviour:
- Clock and reset:
  - Clock is `clock`; reset is `reset_n`, asynchronous and active-low.
  - In reset, all outputs and internal state are 0: a_out, b_out, fwd_valid, out, out_valid, busy, ovf, product/seed regs, accumulator, beat counter, latched mode.
- Forwarding: a_out/b_out/fwd_valid register a_in/b_in/in_valid every cycle, valid or not. Latency 1.
- Stage 1 (edge N): captures p = a_in*b_in (2*DW, zero-extended or truncated to AW), c_in, valid, eff_mode, first, last.
- Beat counter cnt (clog2(K) bits, min 1) tracks accepted mode-1 beats.
  - first = (cnt == 0); last = (cnt == K-1).
- Mode latching:
  - mode is sampled only when cnt == 0, giving eff_mode.
  - While cnt != 0 the latched mode is used and the mode pin is ignored.
  - A mode change mid-accumulation has no effect until the set completes.
- Bubbles: in_valid = 0 beats do not advance cnt, do not touch the accumulator, and produce no out_valid.
- Mode 0, stage 2 (edge N+1): out <= c + p; out_valid <= 1. Latency 2 from input edge.
- Mode 1, stage 2:
  - acc_new = (first ? c : acc) + p; c_in on non-first beats is ignored.
  - If not last: acc <= acc_new, out_valid <= 0.
  - If last: out <= acc_new, out_valid <= 1, acc <= 0.
  - Result appears 2 edges after the K-th valid beat.
  - K = 1 in mode 1 behaves identically to mode 0.
- Back-to-back: a new set may start the beat after the last beat, with no dead cycle. The first flag selects the seed, so there is no clear hazard.
- Width: all sums are modulo 2^AW unless PE_SAT_EN.
- Output hold: out holds its last value when out_valid = 0.
- busy = (cnt != 0) | stage-1 valid | stage-2 accumulation open.
- Reset mid-operation discards the partial accumulation and the pipeline contents. The next valid beat is a first beat.

Optional Feature:
PE_SAT_EN
- Defined:
  - Every stage-2 add detects unsigned carry-out beyond AW; the product truncation does not count.
  - On carry-out the result saturates to 2^AW-1.
  - In mode 1 the saturation is sticky across the remainder of the set.
  - ovf = 1 with the out_valid of a saturated result.
- Undefined: wrap-around arithmetic; ovf tied 0.

Test Plan:
- Reset: hold reset_n = 0 with random inputs -> all outputs 0. Release, then a_in = 3, b_in = 5, c_in = 7, mode = 0, valid -> a_out = 3 and fwd_valid = 1 after 1 edge; out = 22 with out_valid after 2 edges.
- Mode 1, K = 4: (1,2), (3,4), (5,6), (7,8) with c_in = 10 on beat 1 -> single out_valid, out = 110, 2 edges after beat 4. No out_valid on earlier beats.
- Same stream with 2 bubbles inserted and mode toggled to 0 after beat 2 -> out = 110 still. Immediately follow with (1,1) x4, c = 0 -> out = 4 with no dead cycle.
- Reset during accumulation: 2 beats accepted, then pulse reset_n; then (2,2) x4 with c = 1 -> out = 17, busy = 0 afterwards.
- Overflow, mode 1, K = 2: a = b = 0xFFFFFFFF twice, c = 0 -> without PE_SAT_EN, out = 0xFFFFFFFC00000002 and ovf = 0. With PE_SAT_EN, out = 0xFFFFFFFFFFFFFFFF and ovf = 1.
